// File: rtl/bus_if.sv
// bus_if: master-side bus interface downstream of slave_mux.
// Turns a CPU-side access request into a bus transaction
// (request -> grant -> address strobe -> wait for ready), with a
// wait-state timeout so a hung slave cannot lock up the owning stage.
//
// Ports:
//   clk, reset               single clock, synchronous active-high reset
//   if_req/if_rw/if_addr/    CPU-side access request (level), direction,
//   if_wr_data               address and write data
//   stall, flush             owning-stage control
//   if_rd_data/if_busy/      read data, stage stall request, timeout pulse
//   if_err
//   bus_req/bus_grnt         arbiter handshake
//   bus_as/bus_rw/bus_addr/  registered bus-side outputs
//   bus_wr_data
//   s_ready/s_rd_data        selected slave response from slave_mux
module bus_if #(
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic              if_rw,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [DATA_W-1:0] if_wr_data,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] if_rd_data,
  output logic              if_busy,
  output logic              if_err,
  output logic              bus_req,
  input  logic              bus_grnt,
  output logic              bus_as,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rd_data
);

  localparam int unsigned    CNT_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam bit             TO_EN  = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    STALL  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_bus_req;
  logic               r_bus_as;
  logic               r_rw;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wr_data;
  logic [DATA_W-1:0]  r_rd_buf;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_done;
  logic               w_tout;

  // A ready in the same cycle as the counter limit wins over the timeout.
  assign w_done = (r_state == ACCESS) && s_ready;
  assign w_tout = TO_EN && (r_state == ACCESS) && !s_ready && (r_cnt == TO_VAL);

  // The request/address/data registers double as the bus drivers: they are
  // loaded on acceptance and cleared when the access ends, so the bus reads
  // 0 in IDLE and STALL without extra muxing.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bus_req <= 1'b0;
      r_bus_as  <= 1'b0;
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_rd_buf  <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_bus_as <= 1'b0;
          if (if_req && !flush) begin
            r_rw      <= if_rw;
            r_addr    <= if_addr;
            r_wr_data <= if_wr_data;
            r_bus_req <= 1'b1;
            r_state   <= REQ;
          end
        end
        REQ: begin
          if (bus_grnt) begin
            r_bus_as <= 1'b1;
            r_cnt    <= '0;
            r_state  <= ACCESS;
          end
        end
        ACCESS: begin
          r_bus_as <= 1'b0;
          if (w_done || w_tout) begin
            if (w_done && !r_rw) begin
              r_rd_buf <= s_rd_data;
            end else if (w_tout) begin
              r_rd_buf <= '0;
            end
            r_bus_req <= 1'b0;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_state   <= stall ? STALL : IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STALL: begin
          if (!stall) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    if_busy    = 1'b0;
    if_err     = w_tout;
    if_rd_data = r_rd_buf;
    case (r_state)
      IDLE:    if_busy = if_req && !flush;
      REQ:     if_busy = 1'b1;
      ACCESS: begin
        if_busy = !(w_done || w_tout);
        if (w_done && !r_rw) begin
          if_rd_data = s_rd_data;
        end else if (w_tout) begin
          if_rd_data = '0;
        end
      end
      default: if_busy = 1'b0;
    endcase
  end

  assign bus_req     = r_bus_req;
  assign bus_as      = r_bus_as;
  assign bus_rw      = r_rw;
  assign bus_addr    = r_addr;
  assign bus_wr_data = r_wr_data;

endmodule

// File: tb/tb_bus_if.sv
module tb_bus_if;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic              if_rw;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_wr_data;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] if_rd_data;
  logic              if_busy;
  logic              if_err;
  logic              bus_req;
  logic              bus_grnt;
  logic              bus_as;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wr_data;
  logic              s_ready;
  logic [DATA_W-1:0] s_rd_data;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   busy_cnt;
  int   as_cnt;

  always #5 clk = ~clk;

  bus_if #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_rw      (if_rw),
    .if_addr    (if_addr),
    .if_wr_data (if_wr_data),
    .stall      (stall),
    .flush      (flush),
    .if_rd_data (if_rd_data),
    .if_busy    (if_busy),
    .if_err     (if_err),
    .bus_req    (bus_req),
    .bus_grnt   (bus_grnt),
    .bus_as     (bus_as),
    .bus_rw     (bus_rw),
    .bus_addr   (bus_addr),
    .bus_wr_data(bus_wr_data),
    .s_ready    (s_ready),
    .s_rd_data  (s_rd_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected completion and compare it with the DUT response.
  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rd_data"}, 64'(if_rd_data), 64'(e.data));
      chk({tag, "_err"}, 64'(if_err), 64'(e.err));
    end
  endtask

  // Advance one clock: inputs are driven just after the falling edge and
  // outputs are sampled 1 time unit later, well away from the rising edge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_rw = 1'b0; if_addr = '0; if_wr_data = '0;
    stall = 1'b0; flush = 1'b0; bus_grnt = 1'b0; s_ready = 1'b0; s_rd_data = '0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #1;
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_bus_as", 64'(bus_as), 64'd0);
    chk("rst_bus_rw", 64'(bus_rw), 64'd0);
    chk("rst_bus_addr", 64'(bus_addr), 64'd0);
    chk("rst_bus_wr_data", 64'(bus_wr_data), 64'd0);
    chk("rst_rd_data", 64'(if_rd_data), 64'd0);
    chk("rst_err", 64'(if_err), 64'd0);
    chk("rst_busy", 64'(if_busy), 64'd0);

    // ---- read, zero wait ----
    next_cycle();
    if_req = 1'b1; if_rw = 1'b0; if_addr = 30'h10;
    sb.push_back('{data: 32'hDEADBEEF, err: 1'b0});
    #1;
    chk("rd0_c0_busy", 64'(if_busy), 64'd1);
    chk("rd0_c0_bus_req", 64'(bus_req), 64'd0);
    next_cycle();
    if_req = 1'b0; if_addr = '0; bus_grnt = 1'b1;
    #1;
    chk("rd0_c1_busy", 64'(if_busy), 64'd1);
    chk("rd0_c1_bus_req", 64'(bus_req), 64'd1);
    chk("rd0_c1_bus_as", 64'(bus_as), 64'd0);
    chk("rd0_c1_bus_addr", 64'(bus_addr), 64'h10);
    next_cycle();
    bus_grnt = 1'b0; s_ready = 1'b1; s_rd_data = 32'hDEADBEEF;
    #1;
    chk("rd0_c2_bus_as", 64'(bus_as), 64'd1);
    chk("rd0_c2_busy", 64'(if_busy), 64'd0);
    sb_check("rd0_c2");
    next_cycle();
    s_ready = 1'b0; s_rd_data = '0;
    #1;
    chk("rd0_c3_bus_req", 64'(bus_req), 64'd0);
    chk("rd0_c3_bus_as", 64'(bus_as), 64'd0);
    chk("rd0_c3_bus_addr", 64'(bus_addr), 64'd0);
    chk("rd0_c3_rd_buf", 64'(if_rd_data), 64'hDEADBEEF);

    // ---- write, 3 grant waits, ready in 4th ACCESS cycle ----
    busy_cnt = 0;
    as_cnt   = 0;
    for (int k = 0; k <= 8; k++) begin
      next_cycle();
      if_req     = (k == 0);
      if_rw      = (k == 0);
      if_wr_data = (k == 0) ? 32'h12345678 : 32'h0;
      if_addr    = (k == 0) ? 30'h20 : 30'h0;
      bus_grnt   = (k == 4);
      s_ready    = (k == 8);
      s_rd_data  = (k == 8) ? 32'hBADBAD00 : 32'h0;
      #1;
      if (if_busy) busy_cnt++;
      if (bus_as) as_cnt++;
      if (k >= 1) begin
        chk($sformatf("wr_k%0d_wr_data", k), 64'(bus_wr_data), 64'h12345678);
        chk($sformatf("wr_k%0d_rw", k), 64'(bus_rw), 64'd1);
        chk($sformatf("wr_k%0d_as", k), 64'(bus_as), (k == 5) ? 64'd1 : 64'd0);
      end
    end
    next_cycle();
    s_ready = 1'b0; s_rd_data = '0;
    #1;
    chk("wr_busy_cycles", 64'(busy_cnt), 64'd8);
    chk("wr_as_pulses", 64'(as_cnt), 64'd1);
    chk("wr_rd_buf_kept", 64'(if_rd_data), 64'hDEADBEEF);
    chk("wr_end_bus_req", 64'(bus_req), 64'd0);
    chk("wr_end_bus_rw", 64'(bus_rw), 64'd0);

    // ---- timeout (TIMEOUT = 4): err in the 5th ACCESS cycle ----
    next_cycle();
    if_req = 1'b1; if_rw = 1'b0; if_addr = 30'h30;
    sb.push_back('{data: 32'h0, err: 1'b1});
    next_cycle();
    if_req = 1'b0; bus_grnt = 1'b1;
    for (int a = 1; a <= 5; a++) begin
      next_cycle();
      bus_grnt = 1'b0; s_rd_data = 32'hFFFF0000;
      #1;
      if (a < 5) begin
        chk($sformatf("to_a%0d_err", a), 64'(if_err), 64'd0);
        chk($sformatf("to_a%0d_busy", a), 64'(if_busy), 64'd1);
      end else begin
        chk("to_a5_busy", 64'(if_busy), 64'd0);
        sb_check("to_a5");
      end
    end
    next_cycle();
    s_rd_data = '0;
    #1;
    chk("to_next_bus_req", 64'(bus_req), 64'd0);
    chk("to_next_err", 64'(if_err), 64'd0);
    chk("to_next_rd_buf", 64'(if_rd_data), 64'd0);

    // ---- stall hold ----
    next_cycle();
    if_req = 1'b1; if_rw = 1'b0; if_addr = 30'h40;
    sb.push_back('{data: 32'hCAFEF00D, err: 1'b0});
    next_cycle();
    bus_grnt = 1'b1;
    next_cycle();
    bus_grnt = 1'b0; s_ready = 1'b1; s_rd_data = 32'hCAFEF00D; stall = 1'b1;
    #1;
    sb_check("st_done");
    for (int s = 0; s < 3; s++) begin
      next_cycle();
      s_ready = 1'b0; s_rd_data = 32'h0; stall = (s < 2);
      #1;
      chk($sformatf("st_s%0d_busy", s), 64'(if_busy), 64'd0);
      chk($sformatf("st_s%0d_bus_req", s), 64'(bus_req), 64'd0);
      chk($sformatf("st_s%0d_rd", s), 64'(if_rd_data), 64'hCAFEF00D);
    end
    next_cycle();
    if_addr = 30'h44;
    sb.push_back('{data: 32'h55AA55AA, err: 1'b0});
    #1;
    chk("st_idle_busy", 64'(if_busy), 64'd1);
    chk("st_idle_bus_req", 64'(bus_req), 64'd0);
    next_cycle();
    if_req = 1'b0; bus_grnt = 1'b1;
    #1;
    chk("st_new_bus_req", 64'(bus_req), 64'd1);
    chk("st_new_addr", 64'(bus_addr), 64'h44);
    next_cycle();
    bus_grnt = 1'b0; s_ready = 1'b1; s_rd_data = 32'h55AA55AA;
    #1;
    sb_check("st_new_done");

    // ---- flush ----
    next_cycle();
    s_ready = 1'b0; s_rd_data = '0;
    if_req = 1'b1; flush = 1'b1; if_addr = 30'h50;
    #1;
    chk("fl_idle_busy", 64'(if_busy), 64'd0);
    next_cycle();
    flush = 1'b0; if_req = 1'b0;
    #1;
    chk("fl_idle_no_req", 64'(bus_req), 64'd0);
    next_cycle();
    if_req = 1'b1; if_addr = 30'h54;
    sb.push_back('{data: 32'h0BADF00D, err: 1'b0});
    next_cycle();
    if_req = 1'b0; bus_grnt = 1'b1; flush = 1'b1;
    next_cycle();
    bus_grnt = 1'b0; flush = 1'b1;
    #1;
    chk("fl_acc_busy", 64'(if_busy), 64'd1);
    chk("fl_acc_bus_req", 64'(bus_req), 64'd1);
    next_cycle();
    flush = 1'b0; s_ready = 1'b1; s_rd_data = 32'h0BADF00D;
    #1;
    chk("fl_acc_done_busy", 64'(if_busy), 64'd0);
    sb_check("fl_acc_done");

    // ---- reset mid-ACCESS ----
    next_cycle();
    s_ready = 1'b0; s_rd_data = '0;
    if_req = 1'b1; if_addr = 30'h60;
    next_cycle();
    if_req = 1'b0; bus_grnt = 1'b1;
    next_cycle();
    bus_grnt = 1'b0; reset = 1'b1;
    #1;
    chk("rm_acc_bus_as", 64'(bus_as), 64'd1);
    chk("rm_acc_rd_buf", 64'(if_rd_data), 64'h0BADF00D);
    next_cycle();
    reset = 1'b0;
    #1;
    chk("rm_bus_req", 64'(bus_req), 64'd0);
    chk("rm_bus_as", 64'(bus_as), 64'd0);
    chk("rm_bus_addr", 64'(bus_addr), 64'd0);
    chk("rm_rd_data", 64'(if_rd_data), 64'd0);
    next_cycle();
    if_req = 1'b1; if_addr = 30'h64;
    #1;
    chk("rm_idle_busy", 64'(if_busy), 64'd1);
    next_cycle();
    if_req = 1'b0;
    #1;
    chk("rm_idle_accept", 64'(bus_req), 64'd1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
